mipi_bitslip_ctrl: RTL



---
 rtl/mipi_bitslip_ctrl_if.sv | 35 +++
 rtl/mipi_bitslip_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mipi_bitslip_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_bitslip_ctrl_if
//  Description : Bus bundle between the D-PHY front end / CSI-2 packet layer
//                and the byte-alignment controller.
//                master : drives I_Align_Req, I_Lane_Data; observes outputs
//                slave  : the alignment controller itself
//  Revision    : 1.0  initial release
// ============================================================================
interface mipi_bitslip_ctrl_if #(
    parameter int LANE_NUM = 2
);
    logic                  I_Align_Req;    // start/restart alignment pulse
    logic [8*LANE_NUM-1:0] I_Lane_Data;    // ISERDES bytes, lane0 in [7:0]
    logic [LANE_NUM-1:0]   O_Bitslip;      // one-cycle bitslip per lane
    logic [LANE_NUM-1:0]   O_Lane_Locked;  // lane aligned
    logic                  O_All_Locked;   // every lane aligned
    logic                  O_Fail;         // some lane ran out of slip positions
    logic                  O_Busy;         // some lane still searching
    logic [8*LANE_NUM-1:0] O_Lane_Data;    // registered lane bytes
    logic                  O_Data_Valid;   // qualifies O_Lane_Data

    modport master (
        output I_Align_Req, I_Lane_Data,
        input  O_Bitslip, O_Lane_Locked, O_All_Locked, O_Fail, O_Busy,
               O_Lane_Data, O_Data_Valid
    );

    modport slave (
        input  I_Align_Req, I_Lane_Data,
        output O_Bitslip, O_Lane_Locked, O_All_Locked, O_Fail, O_Busy,
               O_Lane_Data, O_Data_Valid
    );
endinterface
`default_nettype wire

// File: rtl/mipi_bitslip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_bitslip_ctrl
//  Description : Per-lane byte-alignment controller for the MIPI D-PHY RX
//                path. Each lane hunts for SYNC_BYTE on its registered
//                ISERDES byte, pulsing Bitslip between search windows until
//                the sync byte is found or every slip position is exhausted.
//  Ports       : Clk, Rst (sync, active-high)
//                bus.slave : I_Align_Req, I_Lane_Data      (in)
//                            O_Bitslip, O_Lane_Locked, O_All_Locked, O_Fail,
//                            O_Busy, O_Lane_Data, O_Data_Valid (out)
//  Revision    : 1.0  initial release
// ============================================================================
module mipi_bitslip_ctrl #(
    parameter int          LANE_NUM  = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'hB8,
    parameter int          HUNT_WIN  = 64,
    parameter int          SLIP_WAIT = 4,
    parameter int          MAX_SLIP  = 7
) (
    input  wire logic              Clk,
    input  wire logic              Rst,
    mipi_bitslip_ctrl_if.slave     bus
);

    localparam int WIN_W  = (HUNT_WIN  > 1) ? $clog2(HUNT_WIN)   : 1;
    localparam int SLIP_W = (MAX_SLIP  > 0) ? $clog2(MAX_SLIP+1) : 1;
    localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT)  : 1;

    localparam logic [WIN_W-1:0]  c_win_last  = WIN_W'(HUNT_WIN - 1);
    localparam logic [SLIP_W-1:0] c_slip_max  = SLIP_W'(MAX_SLIP);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    logic [8*LANE_NUM-1:0] r_data;
    logic [LANE_NUM-1:0]   w_bitslip;
    logic [LANE_NUM-1:0]   w_locked;
    logic [LANE_NUM-1:0]   w_fail;
    logic [LANE_NUM-1:0]   w_busy;

    // Single input register: both the comparators and the forwarded data
    // use this copy, so lock and valid line up with O_Lane_Data.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_data <= '0;
        end else begin
            r_data <= bus.I_Lane_Data;
        end
    end

    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
        state_t              r_state;
        logic [WIN_W-1:0]    r_win_cnt;
        logic [SLIP_W-1:0]   r_slip_cnt;
        logic [WAIT_W-1:0]   r_wait_cnt;
        logic                r_bitslip;
        logic                r_locked;
        logic                r_fail;
        logic                w_match;

        assign w_match = (r_data[8*i +: 8] == SYNC_BYTE);

        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_state    <= ST_IDLE;
                r_win_cnt  <= '0;
                r_slip_cnt <= '0;
                r_wait_cnt <= '0;
                r_bitslip  <= 1'b0;
                r_locked   <= 1'b0;
                r_fail     <= 1'b0;
            end else if (bus.I_Align_Req) begin
                // Restart from any state; a pulse already on the wire this
                // cycle has been seen by the PHY and simply ends here.
                r_state    <= ST_HUNT;
                r_win_cnt  <= '0;
                r_slip_cnt <= '0;
                r_wait_cnt <= '0;
                r_bitslip  <= 1'b0;
                r_locked   <= 1'b0;
                r_fail     <= 1'b0;
            end else begin
                r_bitslip <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_HUNT: begin
                        if (w_match) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end else if (r_win_cnt == c_win_last) begin
                            if (r_slip_cnt < c_slip_max) begin
                                // Pulse is registered so it is high exactly
                                // while the lane sits in SLIP.
                                r_state   <= ST_SLIP;
                                r_bitslip <= 1'b1;
                            end else begin
                                r_state <= ST_FAIL;
                                r_fail  <= 1'b1;
                            end
                        end else begin
                            r_win_cnt <= r_win_cnt + WIN_W'(1);
                        end
                    end
                    ST_SLIP: begin
                        r_slip_cnt <= r_slip_cnt + SLIP_W'(1);
                        r_win_cnt  <= '0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // Comparator ignored while the ISERDES output settles.
                        if (r_wait_cnt == c_wait_last) begin
                            r_state   <= ST_HUNT;
                            r_win_cnt <= '0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        r_state <= ST_LOCKED;
                    end
                    ST_FAIL: begin
                        r_state <= ST_FAIL;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign w_bitslip[i] = r_bitslip;
        assign w_locked[i]  = r_locked;
        assign w_fail[i]    = r_fail;
        assign w_busy[i]    = (r_state == ST_HUNT) || (r_state == ST_SLIP) ||
                              (r_state == ST_WAIT);
    end

    assign bus.O_Bitslip     = w_bitslip;
    assign bus.O_Lane_Locked = w_locked;
    assign bus.O_All_Locked  = &w_locked;
    assign bus.O_Fail        = |w_fail;
    assign bus.O_Busy        = |w_busy;
    assign bus.O_Lane_Data   = r_data;
    assign bus.O_Data_Valid  = &w_locked;

endmodule
`default_nettype wire
